// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive checker placed beside the two-road traffic-light controller. It
// samples the six lamp lines and the controller mode input every clock. It
// locks onto the four-phase sequence P0 -> P1 -> P2 -> P3 -> P0 and flags
// these violations on sticky error bits:
//   - conflicting right-of-way
//   - lamp patterns that are not legal
//   - out-of-order phase changes
//   - phases that are too short or too long
// It also counts completed signal cycles. It never drives the lamps.
//
// Ports:
//   clk           single clock, all state on the rising edge
//   rst           asynchronous, active-high reset
//   clr_err       synchronous clear of all error flags (a new violation wins)
//   m             controller mode, 1 = maintenance/flash
//   r1,y1,g1      road 1 lamps
//   r2,y2,g2      road 2 lamps
//   phase         tracked phase 0..3, meaningful while in_sync = 1
//   in_sync       monitor is locked to the sequence
//   err_conflict  sticky: conflicting right-of-way seen
//   err_illegal   sticky: lamp pattern outside the four legal ones
//   err_sequence  sticky: legal pattern arrived out of order
//   err_dwell     sticky: phase shorter than its minimum or longer than MAX_DWELL
//   cycle_count   completed P3->P0 transitions, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DWELL  = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_err,
  input  logic             m,
  input  logic             r1,
  input  logic             y1,
  input  logic             g1,
  input  logic             r2,
  input  logic             y2,
  input  logic             g2,
  output logic [1:0]       phase,
  output logic             in_sync,
  output logic             err_conflict,
  output logic             err_illegal,
  output logic             err_sequence,
  output logic             err_dwell,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(MAX_DWELL + 2);

  localparam logic [DW-1:0] MIN_G_D = DW'(MIN_GREEN);
  localparam logic [DW-1:0] MIN_Y_D = DW'(MIN_YELLOW);
  localparam logic [DW-1:0] MAX_D   = DW'(MAX_DWELL);
  localparam logic [DW-1:0] SAT_D   = DW'(MAX_DWELL + 1);
  localparam logic [DW-1:0] ONE_D   = DW'(1);

  // Lamp patterns written {r1,y1,g1,r2,y2,g2}.
  localparam logic [5:0] PAT_P0 = 6'b001_100;
  localparam logic [5:0] PAT_P1 = 6'b010_100;
  localparam logic [5:0] PAT_P2 = 6'b100_001;
  localparam logic [5:0] PAT_P3 = 6'b100_010;

  typedef enum logic {SYNC, TRACK} state_t;

  state_t          state;
  logic [DW-1:0]   dwell;
  // Set for the phase we locked onto: its start was never observed, so its
  // length tells us nothing and it is exempt from both dwell limits.
  logic            first;

  logic [5:0]      pat;
  logic            legal;
  logic [1:0]      idx;
  logic            conflict;
  logic [1:0]      next_phase;
  logic [DW-1:0]   min_dwell;

  assign pat        = {r1, y1, g1, r2, y2, g2};
  assign next_phase = phase + 2'd1;
  // Odd phases are the yellow ones.
  assign min_dwell  = phase[0] ? MIN_Y_D : MIN_G_D;
  // Flash mode legitimately shows both yellows, so only green/green conflicts.
  assign conflict   = m ? (g1 & g2) : ((g1 | y1) & (g2 | y2));
  assign in_sync    = (state == TRACK);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case (pat)
      PAT_P0:  idx = 2'd0;
      PAT_P1:  idx = 2'd1;
      PAT_P2:  idx = 2'd2;
      PAT_P3:  idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the value from before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SYNC;
      phase        <= 2'd0;
      dwell        <= '0;
      first        <= 1'b0;
      err_conflict <= 1'b0;
      err_illegal  <= 1'b0;
      err_sequence <= 1'b0;
      err_dwell    <= 1'b0;
      cycle_count  <= '0;
    end else begin
      // NOTE: the clear comes first, so a violation set later in this block
      // overrides it (the last non-blocking assignment wins).
      if (clr_err) begin
        err_conflict <= 1'b0;
        err_illegal  <= 1'b0;
        err_sequence <= 1'b0;
        err_dwell    <= 1'b0;
      end

      if (conflict) err_conflict <= 1'b1;

      if (m) begin
        // Flash mode: drop lock and check nothing beyond conflicts.
        state <= SYNC;
      end else begin
        case (state)
          SYNC: begin
            if (legal) begin
              state <= TRACK;
              phase <= idx;
              dwell <= ONE_D;
              first <= 1'b1;
            end
          end

          TRACK: begin
            if (!legal) begin
              err_illegal <= 1'b1;
              state       <= SYNC;
            end else if (idx == phase) begin
              if (dwell != SAT_D) dwell <= dwell + ONE_D;
              // dwell >= MAX now means dwell > MAX after this sample.
              if (!first && (dwell >= MAX_D)) err_dwell <= 1'b1;
            end else if (idx == next_phase) begin
              if (!first && (dwell < min_dwell)) err_dwell <= 1'b1;
              phase <= idx;
              dwell <= ONE_D;
              first <= 1'b0;
              if (phase == 2'd3) cycle_count <= cycle_count + 1'b1;
            end else begin
              // Out-of-order legal pattern: re-lock onto it.
              err_sequence <= 1'b1;
              phase        <= idx;
              dwell        <= ONE_D;
              first        <= 1'b1;
            end
          end

          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Directed scenarios for traffic_light_monitor. Each scenario builds a table
// of lamp/mode/clear stimulus with the hand-derived output expected after the
// sampling edge. Expectations go through a scoreboard queue: pushed when the
// stimulus is driven, popped and compared once the DUT has registered it.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_err;
  logic       m;
  logic       r1, y1, g1, r2, y2, g2;
  logic [1:0] phase;
  logic       in_sync;
  logic       err_conflict, err_illegal, err_sequence, err_dwell;
  logic [7:0] cycle_count;

  localparam logic [5:0] P0   = 6'b001_100;
  localparam logic [5:0] P1   = 6'b010_100;
  localparam logic [5:0] P2   = 6'b100_001;
  localparam logic [5:0] P3   = 6'b100_010;
  localparam logic [5:0] OFF  = 6'b000_000;
  localparam logic [5:0] GG   = 6'b001_001;
  localparam logic [5:0] YY   = 6'b010_010;

  typedef struct packed {
    logic [1:0] ph;
    logic       sync;
    logic       ec;
    logic       ei;
    logic       es;
    logic       ed;
    logic [7:0] cnt;
  } obs_t;

  typedef struct packed {
    logic [5:0] pat;
    logic       mode;
    logic       clr;
    obs_t       exp;
  } stim_t;

  obs_t obs;
  assign obs = {phase, in_sync, err_conflict, err_illegal, err_sequence,
                err_dwell, cycle_count};

  obs_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  traffic_light_monitor #(
    .MIN_GREEN (4),
    .MIN_YELLOW(2),
    .MAX_DWELL (64),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr_err     (clr_err),
    .m           (m),
    .r1          (r1),
    .y1          (y1),
    .g1          (g1),
    .r2          (r2),
    .y2          (y2),
    .g2          (g2),
    .phase       (phase),
    .in_sync     (in_sync),
    .err_conflict(err_conflict),
    .err_illegal (err_illegal),
    .err_sequence(err_sequence),
    .err_dwell   (err_dwell),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [1:0] ph, input logic s,
                              input logic ec, input logic ei, input logic es,
                              input logic ed, input logic [7:0] c);
    return obs_t'({ph, s, ec, ei, es, ed, c});
  endfunction

  function automatic logic [5:0] pat_of(input logic [1:0] ph);
    case (ph)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  // Apply one sample between edges, then wait past the sampling edge.
  task automatic drive(input logic [5:0] p, input logic mi, input logic ci);
    @(negedge clk);
    {r1, y1, g1, r2, y2, g2} = p;
    m       = mi;
    clr_err = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {r1, y1, g1, r2, y2, g2} = OFF;
    m       = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Push G=4,Y=2 loop samples; loop index l gives the expected count.
  task automatic add_loop(inout stim_t s[$], input logic [7:0] c);
    for (int ph = 0; ph < 4; ph++)
      for (int d = 0; d < ((ph % 2 == 0) ? 4 : 2); d++)
        s.push_back('{pat_of(2'(ph)), 1'b0, 1'b0,
                      mk(2'(ph), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c)});
  endtask

  task automatic test_reset();
    stim_t s[$];
    obs_t  e;
    rst = 1'b1;
    {r1, y1, g1, r2, y2, g2} = OFF;
    m = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (obs !== obs_t'(0))
      $display("FAIL reset_held: got %h, want %h", obs, obs_t'(0));
    else
      n_pass++;
    @(negedge clk);
    rst = 1'b0;
    // All lamps dark while unlocked: nothing happens.
    s.push_back('{OFF, 1'b0, 1'b0, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].pat, s[i].mode, s[i].clr);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL reset step %0d: got %h, want %h", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_legal_loop();
    stim_t s[$];
    obs_t  e;
    do_reset();
    for (int l = 0; l < 3; l++) add_loop(s, 8'(l));
    s.push_back('{P0, 1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3)});
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].pat, s[i].mode, s[i].clr);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL legal_loop step %0d: got %h, want %h", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_short_yellow();
    stim_t s[$];
    obs_t  e;
    do_reset();
    repeat (4) s.push_back('{P0, 1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    s.push_back('{P1, 1'b0, 1'b0, mk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    s.push_back('{P2, 1'b0, 1'b0, mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0)});
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].pat, s[i].mode, s[i].clr);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL short_yellow step %0d: got %h, want %h", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_max_dwell();
    stim_t s[$];
    obs_t  e;
    do_reset();
    repeat (4) s.push_back('{P0, 1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    repeat (2) s.push_back('{P1, 1'b0, 1'b0, mk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    // The 65th P2 sample (index 64) is the first one beyond MAX_DWELL.
    for (int i = 0; i < 70; i++)
      s.push_back('{P2, 1'b0, 1'b0,
                    mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, (i >= 64), 8'd0)});
    // A saturated counter still exceeds the limit, so the flag re-sets over
    // the clear; a wrapped counter would let it drop.
    s.push_back('{P2, 1'b0, 1'b1, mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0)});
    s.push_back('{P2, 1'b0, 1'b0, mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0)});
    // A long phase exits without a minimum violation, so the clear takes hold.
    s.push_back('{P3, 1'b0, 1'b1, mk(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].pat, s[i].mode, s[i].clr);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL max_dwell step %0d: got %h, want %h", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_sequence();
    stim_t s[$];
    obs_t  e;
    do_reset();
    repeat (4) s.push_back('{P0, 1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    // P0 -> P2 skips P1; re-lock on P2, held only one sample (unchecked).
    s.push_back('{P2, 1'b0, 1'b0, mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0)});
    repeat (2) s.push_back('{P3, 1'b0, 1'b0, mk(2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0)});
    s.push_back('{P0, 1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1)});
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].pat, s[i].mode, s[i].clr);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL sequence step %0d: got %h, want %h", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_conflict();
    stim_t s[$];
    obs_t  e;
    do_reset();
    repeat (2) s.push_back('{P0, 1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    repeat (2) s.push_back('{GG, 1'b0, 1'b0, mk(2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0)});
    s.push_back('{OFF, 1'b0, 1'b1, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    s.push_back('{P0,  1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].pat, s[i].mode, s[i].clr);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL conflict step %0d: got %h, want %h", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_flash_and_async_reset();
    stim_t s[$];
    obs_t  e;
    do_reset();
    add_loop(s, 8'd0);
    s.push_back('{P0, 1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1)});
    s.push_back('{YY, 1'b1, 1'b0, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1)});
    repeat (10) s.push_back('{OFF, 1'b1, 1'b0, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1)});
    s.push_back('{P0, 1'b0, 1'b0, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1)});
    s.push_back('{P1, 1'b0, 1'b0, mk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1)});
    foreach (s[i]) begin
      exp_q.push_back(s[i].exp);
      drive(s[i].pat, s[i].mode, s[i].clr);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL flash step %0d: got %h, want %h", i, obs, e);
      else n_pass++;
    end
    // Mid-cycle reset, no clock edge in between.
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (obs !== obs_t'(0))
      $display("FAIL async_reset: got %h, want %h", obs, obs_t'(0));
    else
      n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legal_loop();
    test_short_yellow();
    test_max_dwell();
    test_sequence();
    test_conflict();
    test_flash_and_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
